// File: rtl/avalon_stream_burst_writer.sv
// ---------------------------------------------------------------------------
// avalon_stream_burst_writer
//
// Purpose:
//   Avalon-MM burst write host. Buffers a valid/ready stream of 32-bit words
//   in an internal FIFO and writes them out as Avalon write bursts at
//   consecutive word addresses, starting at a programmed byte base address.
//   A one-cycle done pulse marks the acceptance of the last beat.
//
// Optional feature (compile-time macro BURST_ALIGN_EN):
//   When defined, no burst crosses a (4*MAXB)-byte aligned boundary, so an
//   unaligned base produces a short first burst followed by aligned bursts.
//   When undefined, bursts are simply min(MAXB, words remaining).
//
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   start              launch pulse, sampled only in IDLE
//   base_addr          byte start address, bits [1:0] forced to zero
//   length             number of words to write
//   busy, done         status: busy during a transfer, done one-cycle pulse
//   s_valid/s_ready    stream handshake, s_data is the stream word
//   avm_*              Avalon-MM burst write host signals
//   dbg_state          current FSM state (0 IDLE, 1 FILL, 2 BURST, 3 DONE)
//
// Handshake semantics:
//   Stream: a word moves when s_valid && s_ready in the same cycle; s_ready
//   depends only on internal registers, never on s_valid.
//   Avalon: a beat is accepted when avm_write && !avm_waitrequest; while
//   waitrequest is high every avm_* output is held stable.
// ---------------------------------------------------------------------------
module avalon_stream_burst_writer #(
  parameter int ADDR_W       = 32,
  parameter int BURSTCOUNT_W = 4,
  parameter int FIFO_AW      = 4,
  parameter int LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LEN_W-1:0]        length,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  input  logic [31:0]             s_data,
  output logic                    s_ready,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  output logic [3:0]              avm_byteenable,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic                    avm_waitrequest,
  output logic [1:0]              dbg_state
);

  localparam int MAXB  = 2 ** (BURSTCOUNT_W - 1);
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [LEN_W-1:0]        acc_left_q, acc_left_d;
  logic [LEN_W-1:0]        wr_left_q, wr_left_d;
  logic [ADDR_W-1:0]       next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]       address_q, address_d;
  logic                    write_q, write_d;
  logic [31:0]             writedata_q, writedata_d;
  logic [BURSTCOUNT_W-1:0] burstcount_q, burstcount_d;
  logic [BURSTCOUNT_W-1:0] beats_left_q, beats_left_d;
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        count_q, count_d;

  logic [31:0]             mem [DEPTH];
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic [FIFO_AW-1:0]      rd_idx_nxt;
  logic [LEN_W-1:0]        n_len;
`ifdef BURST_ALIGN_EN
  logic [LEN_W-1:0]        room;
`endif

  assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign s_ready    = busy_q && (acc_left_q != '0) && !fifo_full;
  assign push       = s_valid && s_ready;
  assign pop        = (state_q == BURST) && write_q && !avm_waitrequest;
  assign rd_idx_nxt = rd_ptr_q + FIFO_AW'(1);

  // Size of the next burst.
  always_comb begin
    n_len = (wr_left_q < LEN_W'(MAXB)) ? wr_left_q : LEN_W'(MAXB);
`ifdef BURST_ALIGN_EN
    // Words left before the next (4*MAXB)-byte boundary.
    room = LEN_W'(MAXB) - LEN_W'(next_addr_q[2 +: BURSTCOUNT_W-1]);
    if (room < n_len) begin
      n_len = room;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    acc_left_d   = acc_left_q;
    wr_left_d    = wr_left_q;
    next_addr_d  = next_addr_q;
    address_d    = address_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    burstcount_d = burstcount_q;
    beats_left_d = beats_left_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    // FIFO bookkeeping; simultaneous push and pop leave occupancy unchanged.
    if (push) begin
      wr_ptr_d   = wr_ptr_q + FIFO_AW'(1);
      acc_left_d = acc_left_q - LEN_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_idx_nxt;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            next_addr_d = base_addr & ~(ADDR_W'(3));
            acc_left_d  = length;
            wr_left_d   = length;
            busy_d      = 1'b1;
            state_d     = FILL;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      FILL: begin
        // Only launch once the whole burst is buffered, so the burst never
        // has to stall on the stream side.
        if (LEN_W'(count_q) >= n_len) begin
          address_d    = next_addr_q;
          burstcount_d = BURSTCOUNT_W'(n_len);
          beats_left_d = BURSTCOUNT_W'(n_len);
          writedata_d  = mem[rd_ptr_q];
          write_d      = 1'b1;
          state_d      = BURST;
        end
      end

      BURST: begin
        if (pop) begin
          wr_left_d = wr_left_q - LEN_W'(1);
          if (beats_left_q == BURSTCOUNT_W'(1)) begin
            write_d     = 1'b0;
            next_addr_d = next_addr_q + (ADDR_W'(burstcount_q) << 2);
            if (wr_left_q == LEN_W'(1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              state_d = FILL;
            end
          end else begin
            beats_left_d = beats_left_q - BURSTCOUNT_W'(1);
            writedata_d  = mem[rd_idx_nxt];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      acc_left_q   <= '0;
      wr_left_q    <= '0;
      next_addr_q  <= '0;
      address_q    <= '0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      burstcount_q <= '0;
      beats_left_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      acc_left_q   <= acc_left_d;
      wr_left_q    <= wr_left_d;
      next_addr_q  <= next_addr_d;
      address_q    <= address_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      burstcount_q <= burstcount_d;
      beats_left_q <= beats_left_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = address_q;
  assign avm_write      = write_q;
  assign avm_writedata  = writedata_q;
  assign avm_byteenable = 4'hF;
  assign avm_burstcount = burstcount_q;
  assign dbg_state      = state_q;

endmodule
